// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word plus the memory-arbiter state and requester enums.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_req_t;

    // Snapshot of the granted request, held for the whole memory transaction.
    typedef struct packed {
        logic      write;
        rv32i_word address;
        logic [3:0] byte_enable;
        rv32i_word wdata;
    } arb_latch_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter onto one shared memory port.
// Latency: request seen in IDLE at cycle N drives the memory command at N+1; resp is combinational with mem_resp.
// Backpressure: requesters hold their request until resp; memory command held until mem_resp; one IDLE cycle between transactions.
module mem_arbiter
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,

    input  logic       i_read,
    input  rv32i_word  i_address,
    output rv32i_word  i_rdata,
    output logic       i_resp,

    input  logic       d_read,
    input  logic       d_write,
    input  logic [3:0] d_byte_enable,
    input  rv32i_word  d_address,
    input  rv32i_word  d_wdata,
    output rv32i_word  d_rdata,
    output logic       d_resp,

    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable,
    output rv32i_word  mem_address,
    output rv32i_word  mem_wdata,
    input  rv32i_word  mem_rdata,
    input  logic       mem_resp
);

    arb_state_t state, state_nxt;
    arb_req_t   last_grant, last_grant_nxt;
    arb_latch_t req_lat, req_lat_nxt;
    logic       d_pend;

    assign d_pend = d_read | d_write;

    // Next-state, grant selection and command/response outputs.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        req_lat_nxt    = req_lat;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_resp         = 1'b0;
        d_resp         = 1'b0;

        case (state)
            IDLE: begin
                // Fetch wins when alone, or on a tie when data was served last.
                if (i_read && (!d_pend || last_grant == ARB_D)) begin
                    state_nxt   = SERVE_I;
                    req_lat_nxt = '{write: 1'b0, address: i_address,
                                    byte_enable: BE_ALL, wdata: '0};
                end else if (d_pend) begin
                    state_nxt   = SERVE_D;
                    // A simultaneous read+write is treated as a write.
                    req_lat_nxt = '{write: d_write, address: d_address,
                                    byte_enable: d_write ? d_byte_enable : BE_ALL,
                                    wdata: d_wdata};
                end
            end
            SERVE_I: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    i_resp         = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = ARB_I;
                end
            end
            SERVE_D: begin
                mem_write = req_lat.write;
                mem_read  = ~req_lat.write;
                if (mem_resp) begin
                    d_resp         = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = ARB_D;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A reset cycle aborts any transaction without a response or command.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            i_resp    = 1'b0;
            d_resp    = 1'b0;
        end
    end

    // FSM state and round-robin history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ARB_D;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Request latch: captured on grant so the port ignores later requester changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_lat <= '0;
        end else begin
            req_lat <= req_lat_nxt;
        end
    end

    assign mem_address     = req_lat.address;
    assign mem_byte_enable = req_lat.byte_enable;
    assign mem_wdata       = req_lat.wdata;
    assign i_rdata         = mem_rdata;
    assign d_rdata         = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand sequences, random traffic vs a reference model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        exp_rd, exp_wr;
        logic [3:0]  exp_be;
        logic        exp_to_d;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = 0;
        d_read = 0; d_write = 0; d_byte_enable = 0; d_address = 0; d_wdata = 0;
        mem_rdata = 0; mem_resp = 0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_mem_read"}, mem_read, 0);
        chk({nm, "_mem_write"}, mem_write, 0);
        chk({nm, "_i_resp"}, i_resp, 0);
        chk({nm, "_d_resp"}, d_resp, 0);
    endtask

    task automatic do_reset();
        tick();
        clear_inputs();
        rst = 1;
        tick();
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_mem_address", mem_address, 0);
        chk("reset_mem_be", mem_byte_enable, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
    endtask

    // One isolated transaction from IDLE; the requester's address moves mid-flight.
    task automatic run_vec(input int n);
        vec_t v;
        string nm;
        v  = tbl[n];
        nm = $sformatf("vec%0d", n);
        tick();
        clear_inputs();
        i_read = v.ir; i_address = v.addr;
        d_read = v.dr; d_write = v.dw; d_address = v.addr;
        d_byte_enable = v.be; d_wdata = v.wdata;
        @(negedge clk);
        chk({nm, "_idle_cmd"}, {mem_read, mem_write}, 2'b00);
        for (int k = 1; k < v.lat; k++) begin
            tick();
            i_address = v.addr + 32'h100;
            d_address = v.addr + 32'h100;
            d_wdata   = ~v.wdata;
            @(negedge clk);
            chk({nm, "_rd"}, mem_read, v.exp_rd);
            chk({nm, "_wr"}, mem_write, v.exp_wr);
            chk({nm, "_addr"}, mem_address, v.addr);
            chk({nm, "_be"}, mem_byte_enable, v.exp_be);
            if (v.exp_wr) chk({nm, "_wdata"}, mem_wdata, v.wdata);
            chk({nm, "_early_resp"}, {i_resp, d_resp}, 2'b00);
        end
        tick();
        mem_resp = 1; mem_rdata = v.rdata;
        @(negedge clk);
        chk({nm, "_i_resp"}, i_resp, !v.exp_to_d);
        chk({nm, "_d_resp"}, d_resp, v.exp_to_d);
        chk({nm, "_rdata"}, v.exp_to_d ? d_rdata : i_rdata, v.rdata);
        chk({nm, "_rd_at_resp"}, mem_read, v.exp_rd);
        tick();
        clear_inputs();
        @(negedge clk);
        chk_quiet({nm, "_after"});
    endtask

    // Random-traffic reference model, in terms of port ownership and round-robin history.
    int          owner;      // 0 none, 1 fetch, 2 data
    int          m_last;     // 1 fetch, 2 data
    logic        m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        drop_i, drop_d;

    task automatic run_random(input int cycles);
        logic ip, dp;
        owner = 0; m_last = 2; drop_i = 0; drop_d = 0;
        m_wr = 0; m_addr = 0; m_wdata = 0; m_be = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (drop_i) begin i_read = 0; drop_i = 0; end
            if (drop_d) begin d_read = 0; d_write = 0; drop_d = 0; end
            if (!i_read && ($urandom % 3 == 0)) begin
                i_read = 1; i_address = $urandom;
            end
            if (!(d_read || d_write) && ($urandom % 3 == 0)) begin
                case ($urandom % 3)
                    0:       begin d_read = 1; d_write = 0; end
                    1:       begin d_read = 0; d_write = 1; end
                    default: begin d_read = 1; d_write = 1; end
                endcase
                d_address = $urandom; d_wdata = $urandom;
                d_byte_enable = 4'($urandom);
            end
            mem_rdata = $urandom;
            mem_resp  = (owner != 0) ? ($urandom % 3 == 0) : ($urandom % 4 == 0);
            @(negedge clk);
            chk("rnd_mem_read", mem_read, owner != 0 && !m_wr);
            chk("rnd_mem_write", mem_write, owner != 0 && m_wr);
            if (owner != 0) begin
                chk("rnd_mem_address", mem_address, m_addr);
                chk("rnd_mem_be", mem_byte_enable, m_be);
                if (m_wr) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_i_resp", i_resp, owner == 1 && mem_resp);
            chk("rnd_d_resp", d_resp, owner == 2 && mem_resp);
            if (owner == 1 && mem_resp) chk("rnd_i_rdata", i_rdata, mem_rdata);
            if (owner == 2 && mem_resp) chk("rnd_d_rdata", d_rdata, mem_rdata);
            // Advance the model to the next cycle.
            ip = i_read;
            dp = d_read | d_write;
            if (owner == 0) begin
                if (ip && dp) owner = (m_last == 2) ? 1 : 2;
                else if (ip)  owner = 1;
                else if (dp)  owner = 2;
                if (owner == 1) begin
                    m_wr = 0; m_addr = i_address; m_be = 4'hF; m_wdata = 0;
                end else if (owner == 2) begin
                    m_wr = d_write; m_addr = d_address; m_wdata = d_wdata;
                    m_be = d_write ? d_byte_enable : 4'hF;
                end
            end else if (mem_resp) begin
                if (owner == 1) drop_i = 1; else drop_d = 1;
                m_last = owner;
                owner  = 0;
            end
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();

        //        ir dr dw addr          wdata         be       lat rdata         rd wr exp_be  to_d
        tbl[0] = '{1, 0, 0, 32'h00000060, 32'h0,        4'b0000, 3, 32'h00000013, 1, 0, 4'hF,   0};
        tbl[1] = '{0, 0, 1, 32'h00000100, 32'hDEADBEEF, 4'b0011, 3, 32'h0,        0, 1, 4'b0011, 1};
        tbl[2] = '{0, 1, 0, 32'h00000200, 32'h0,        4'b0000, 2, 32'hCAFEF00D, 1, 0, 4'hF,   1};
        tbl[3] = '{0, 1, 1, 32'h00000300, 32'h12345678, 4'b0101, 4, 32'h0,        0, 1, 4'b0101, 1};
        tbl[4] = '{1, 0, 0, 32'hFFFFFFFC, 32'h0,        4'b1010, 2, 32'hFFFFFFFF, 1, 0, 4'hF,   0};

        do_reset();
        tick();
        rst = 0;
        for (int n = 0; n < 5; n++) run_vec(n);

        // Both requesters held from reset: grants alternate I, D, I, D with one IDLE cycle between.
        do_reset();
        tick();
        rst = 0;
        i_read = 1; i_address = 32'h00001000;
        d_read = 1; d_address = 32'h00002000;
        mem_resp = 1; mem_rdata = 32'h0000ABCD;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_mem_read", k), mem_read, k % 2);
            if (k % 2 == 1)
                chk($sformatf("rr%0d_addr", k), mem_address,
                    (k % 4 == 1) ? 32'h00001000 : 32'h00002000);
            chk($sformatf("rr%0d_i_resp", k), i_resp, k % 4 == 1);
            chk($sformatf("rr%0d_d_resp", k), d_resp, k % 4 == 3);
            tick();
        end

        // Reset in the middle of a data write, then a stray mem_resp while idle.
        do_reset();
        tick();
        rst = 0;
        d_write = 1; d_address = 32'h00000100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
        tick();
        @(negedge clk);
        chk("abort_mem_write", mem_write, 1);
        tick();
        rst = 1; mem_resp = 1;
        @(negedge clk);
        chk("abort_d_resp_in_rst", d_resp, 0);
        tick();
        rst = 0; d_write = 0; mem_resp = 1;
        @(negedge clk);
        chk_quiet("abort_late_resp");
        chk("abort_mem_address", mem_address, 0);
        tick();
        mem_resp = 0;
        @(negedge clk);
        chk_quiet("abort_idle");

        do_reset();
        tick();
        rst = 0;
        run_random(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 No parameters; all data widths SHALL be rv32i_word (32 bits).
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 i_read  in  1  instruction-fetch read request, held until i_resp.
REQ-005 i_address  in  32  instruction-fetch byte address.
REQ-006 i_rdata  out  32  read data to fetch requester.
REQ-007 i_resp  out  1  one-cycle completion pulse to fetch requester.
REQ-008 d_read  in  1  data read request, held until d_resp.
REQ-009 d_write  in  1  data write request, held until d_resp.
REQ-010 d_byte_enable  in  4  write byte lanes.
REQ-011 d_address  in  32  data byte address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_rdata  out  32  read data to data requester.
REQ-014 d_resp  out  1  one-cycle completion pulse to data requester.
REQ-015 mem_read, mem_write  out  1 each  shared memory port commands.
REQ-016 mem_byte_enable  out  4; mem_address, mem_wdata  out  32  shared port payload.
REQ-017 mem_rdata  in  32; mem_resp  in  1  shared port return data and completion.

Function
REQ-018 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-019 In IDLE with no request pending, the FSM SHALL remain in IDLE; all mem_* command outputs SHALL be 0.
REQ-020 In IDLE, a pending request SHALL be granted on the next rising edge: i_read -> SERVE_I; d_read|d_write -> SERVE_D.
REQ-021 When both requesters are pending in IDLE, the grant SHALL be round-robin: the requester not granted last wins; last_grant SHALL reset to D, so I wins the first tie.
REQ-022 On grant, the arbiter SHALL latch op, address, byte_enable and wdata; mem_* outputs SHALL be driven from the latch for the whole transaction, independent of later requester changes.
REQ-023 Request-to-memory latency: a request first seen in IDLE at cycle N SHALL produce mem_read/mem_write high at cycle N+1.
REQ-024 In SERVE_x, mem_read/mem_write SHALL stay asserted until mem_resp is sampled high.
REQ-025 On mem_resp in SERVE_x, x_resp SHALL pulse high combinationally in the same cycle with x_rdata = mem_rdata; the FSM SHALL return to IDLE and last_grant SHALL update to x.
REQ-026 The non-granted requester's resp SHALL be 0 at all times; i_rdata/d_rdata SHALL equal mem_rdata at all times (valid only with resp).
REQ-027 If d_read and d_write are both high, the grant SHALL be a write; d_byte_enable is don't-care for reads (mem_byte_enable forced to 4'b1111 on reads).
REQ-028 mem_resp sampled in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-029 A mandatory one-cycle IDLE gap SHALL separate consecutive transactions; worst-case wait for either requester is one full transaction plus two cycles.
REQ-030 mem_write and mem_read SHALL never be high simultaneously.

Reset
REQ-031 On rst, state SHALL become IDLE, last_grant D, latches 0; mem_read, mem_write, i_resp, d_resp 0; mem_byte_enable, mem_address, mem_wdata 0.
REQ-032 rst asserted mid-transaction SHALL abort it with no resp pulse; a late mem_resp after reset falls under REQ-028.

Structure
REQ-033 rv32i_word SHALL come from rv32i_types; an arb_state_t enum (IDLE, SERVE_I, SERVE_D) and an arb_req_t enum (ARB_I, ARB_D) SHALL be added to that shared package.
REQ-034 No sub-module; single FSM plus request latch register in one module.

Verification
REQ-035 Fetch read i_address=0x00000060, mem_resp after 3 cycles with mem_rdata=0x00000013 -> mem_read at N+1, i_resp one cycle with i_rdata=0x00000013, d_resp=0.
REQ-036 Data write d_address=0x00000100, d_wdata=0xDEADBEEF, be=4'b0011 -> mem_write, mem_byte_enable=4'b0011, payload stable until mem_resp; d_resp one cycle.
REQ-037 i_read and d_read both held continuously from reset -> grants alternate I, D, I, D, each separated by one IDLE cycle.
REQ-038 d_address changed to 0x00000200 mid-transaction -> mem_address stays 0x00000100 until mem_resp.
REQ-039 rst pulsed while in SERVE_D, then mem_resp high in IDLE -> no resp pulse, mem_* all 0, FSM in IDLE.
REQ-040 d_read and d_write both high -> mem_write=1, mem_read=0 throughout.
